router_port_rx: RTL and testbench

// - Router-side receiver for one input port of the 16-port router; the counterpart of the testbench driver.
// - Consumes the serial frame_n/valid_n/din stream and decodes a 4-bit destination address, then pad, then LSB-first payload bytes.
// - Queues each byte with its address and sop/eop tags in a local FIFO for the crossbar.
// - Drives busy_n back to the sender as flow control.

---
 rtl/router_pkg.sv | 16 +
 rtl/router_port_rx_if.sv | 31 +++
 rtl/router_rx_fifo.sv | 57 +++++
 rtl/router_port_rx.sv | 175 +++++++++++++++++
 tb/tb_router_port_rx.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types for the router input-port receiver.
package router_pkg;

    localparam int ADDR_BITS = 4;
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, ADDR, PAD, PAYLOAD} rx_state_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0] addr;
        logic                 sop;
        logic                 eop;
        logic [DATA_BITS-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/router_port_rx_if.sv
// Serial ingress stream plus the FWFT byte stream toward the crossbar.
// The sender/consumer side is the master; the receiver is the slave.
interface router_port_rx_if;
    import router_pkg::*;

    logic                 frame_n;
    logic                 valid_n;
    logic                 din;
    logic                 busy_n;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_BITS-1:0] out_data;
    logic [ADDR_BITS-1:0] out_addr;
    logic                 out_sop;
    logic                 out_eop;
    logic                 err_proto;
    logic                 err_ovf;

    modport slave (
        input  frame_n, valid_n, din, out_ready,
        output busy_n, out_valid, out_data, out_addr, out_sop, out_eop,
               err_proto, err_ovf
    );

    modport master (
        output frame_n, valid_n, din, out_ready,
        input  busy_n, out_valid, out_data, out_addr, out_sop, out_eop,
               err_proto, err_ovf
    );

endinterface

// File: rtl/router_rx_fifo.sv
// First-word fall-through FIFO of decoded payload entries.
// The head reads as zero while empty so the port outputs are clean after reset.
module router_rx_fifo
    import router_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  rx_entry_t              din_i,
    output rx_entry_t              dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rx_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // occupancy after this cycle's accepted push/pop
    always_comb begin
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // storage array, no reset needed since the head is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/router_port_rx.sv
// Receiver for one router input port: deserialises address and payload,
// tags bytes with sop/eop and queues them for the crossbar.
//
// state   | meaning
// IDLE    | waiting for frame_n low; first low cycle carries addr[0]
// ADDR    | collecting addr[1..3]
// PAD     | skipping pad cycles before payload
// PAYLOAD | collecting payload bits LSB first, valid_n high = gap
module router_port_rx
    import router_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int PAD_CYCLES  = 5,
    parameter int BUSY_MARGIN = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    router_port_rx_if.slave  port_if
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(PAD_CYCLES + 1);

    rx_state_e            state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]        pad_cnt_q, pad_cnt_d;
    logic [6:0]           byte_q, byte_d;
    logic                 first_q, first_d;
    logic                 push_q, push_d;
    rx_entry_t            entry_q, entry_d;
    logic                 err_proto_q, err_proto_d;
    logic                 err_ovf_q;
    logic                 busy_n_q, busy_n_d;

    rx_entry_t            head;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        fifo_count, count_next;

    logic                 frame_n, valid_n, din;

    assign frame_n = port_if.frame_n;
    assign valid_n = port_if.valid_n;
    assign din     = port_if.din;

    // next-state decode of the serial framing
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bit_cnt_d   = bit_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        byte_d      = byte_q;
        first_d     = first_q;
        push_d      = 1'b0;
        entry_d     = entry_q;
        err_proto_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!frame_n) begin
                    addr_d[0] = din;
                    bit_cnt_d = 3'd1;
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (frame_n) begin
                    err_proto_d = 1'b1;
                end else begin
                    addr_d[bit_cnt_q[1:0]] = din;
                    if (bit_cnt_q == 3'd3) begin
                        pad_cnt_d = PW'(PAD_CYCLES - 1);
                        state_d   = PAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            PAD: begin
                if (frame_n) begin
                    err_proto_d = 1'b1;
                end else if (pad_cnt_q == '0) begin
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                    state_d   = PAYLOAD;
                end else begin
                    pad_cnt_d = pad_cnt_q - PW'(1);
                end
            end
            PAYLOAD: begin
                if (!valid_n) begin
                    if (bit_cnt_q == 3'd7) begin
                        push_d     = 1'b1;
                        entry_d    = '{addr: addr_q, sop: first_q, eop: frame_n,
                                       data: {din, byte_q}};
                        first_d    = 1'b0;
                        bit_cnt_d  = '0;
                        if (frame_n) state_d = IDLE;
                    end else if (frame_n) begin
                        err_proto_d = 1'b1;
                    end else begin
                        byte_d[bit_cnt_q] = din;
                        bit_cnt_d         = bit_cnt_q + 3'd1;
                    end
                end else if (frame_n) begin
                    err_proto_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (err_proto_d) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end
    end

    // occupancy one cycle ahead, used for registered flow control
    always_comb begin
        count_next = fifo_count + CW'(push_q & ~fifo_full)
                   - CW'(port_if.out_ready & ~fifo_empty);
        busy_n_d   = !((CW'(FIFO_DEPTH) - count_next) <= CW'(BUSY_MARGIN));
    end

    // state, shift register, push stage and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bit_cnt_q   <= '0;
            pad_cnt_q   <= '0;
            byte_q      <= '0;
            first_q     <= 1'b0;
            push_q      <= 1'b0;
            entry_q     <= '0;
            err_proto_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            busy_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bit_cnt_q   <= bit_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            byte_q      <= byte_d;
            first_q     <= first_d;
            push_q      <= push_d;
            entry_q     <= entry_d;
            err_proto_q <= err_proto_d;
            err_ovf_q   <= push_q & fifo_full;
            busy_n_q    <= busy_n_d;
        end
    end

    router_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push_q),
        .pop_i   (port_if.out_ready),
        .din_i   (entry_q),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign port_if.out_valid = ~fifo_empty;
    assign port_if.out_data  = head.data;
    assign port_if.out_addr  = head.addr;
    assign port_if.out_sop   = head.sop;
    assign port_if.out_eop   = head.eop;
    assign port_if.busy_n    = busy_n_q;
    assign port_if.err_proto = err_proto_q;
    assign port_if.err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_router_port_rx.sv
// Scoreboard bench for router_port_rx: the sender pushes the entries a packet
// should produce, a monitor pops and compares on every handshake.
module tb_router_port_rx;
    import router_pkg::*;

    localparam int DEPTH  = 16;
    localparam int PADC   = 5;
    localparam int MARGIN = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    router_port_rx_if bus();

    router_port_rx #(.FIFO_DEPTH(DEPTH), .PAD_CYCLES(PADC), .BUSY_MARGIN(MARGIN)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .port_if (bus)
    );

    int        n_tests = 0;
    int        n_fail = 0;
    rx_entry_t exp_q[$];
    rx_entry_t mon_e;
    int        exp_proto = 0, exp_ovf = 0, seen_proto = 0, seen_ovf = 0;
    int        rdy_mode = 1;
    int        pend_j = -1;
    bit        chk_lat = 0, chk_busy = 0;
    logic [7:0] pl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: count error pulses, compare each popped head with the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.err_proto) seen_proto++;
            if (bus.err_ovf)   seen_ovf++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got %0h expected none",
                             {bus.out_addr, bus.out_sop, bus.out_eop, bus.out_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("entry", {bus.out_addr, bus.out_sop, bus.out_eop, bus.out_data}, mon_e);
                end
            end
        end
    end

    // consumer ready driver
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #800us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic f, input logic v, input logic d);
        bus.frame_n = f;
        bus.valid_n = v;
        bus.din     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic post_check(input int j);
        if (chk_lat && j == 0) chk("latency_edge_n1", bus.out_valid, 1);
        if (chk_busy && j == 12) chk("busy_at_13", bus.busy_n, 1);
        if (chk_busy && j == 13) chk("busy_at_14", bus.busy_n, 0);
    endtask

    task automatic pcyc(input logic f, input logic v, input logic d);
        cyc(f, v, d);
        if (pend_j >= 0) begin
            post_check(pend_j);
            pend_j = -1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_data"},  bus.out_data, 0);
        chk({tag, "_out_addr"},  bus.out_addr, 0);
        chk({tag, "_out_sop"},   bus.out_sop, 0);
        chk({tag, "_out_eop"},   bus.out_eop, 0);
        chk({tag, "_err_proto"}, bus.err_proto, 0);
        chk({tag, "_err_ovf"},   bus.err_ovf, 0);
        chk({tag, "_busy_n"},    bus.busy_n, 1);
    endtask

    // gap_mode: 0 none, 1 three gap cycles after bit 2, 2 random gaps
    // keep: bytes the FIFO can still take; later bytes are expected to be dropped
    task automatic send_pkt(input logic [3:0] a, input logic [7:0] data[$], input int gap_mode,
                            input int ab_byte, input int ab_bit, input bit ab_valid,
                            input int keep, input int rst_byte, input int rst_bit);
        int  n;
        bit  last;
        n = data.size();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, a[i]);
        for (int i = 0; i < PADC; i++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int j = 0; j < n; j++) begin
            for (int k = 0; k < 8; k++) begin
                if (j == rst_byte && k == rst_bit) begin
                    chk("rst_entry_queued", bus.out_valid, 1);
                    reset_n = 1'b0;
                    #1;
                    check_reset_outputs("rst_mid");
                    exp_q.delete();
                    bus.frame_n = 1'b1;
                    bus.valid_n = 1'b1;
                    pend_j = -1;
                    #2;
                    reset_n = 1'b1;
                    return;
                end
                if (j == ab_byte && k == ab_bit) begin
                    if (ab_valid) pcyc(1'b1, 1'b0, 1'($urandom_range(0, 1)));
                    else          pcyc(1'b1, 1'b1, 1'b0);
                    exp_proto++;
                    bus.frame_n = 1'b1;
                    bus.valid_n = 1'b1;
                    pend_j = -1;
                    return;
                end
                last = (j == n - 1) && (k == 7);
                pcyc(last, 1'b0, data[j][k]);
                if (k == 7) begin
                    if (j < keep) exp_q.push_back('{addr: a, sop: (j == 0), eop: (j == n - 1), data: data[j]});
                    else          exp_ovf++;
                    if (chk_lat && j == 0) chk("latency_edge_n", bus.out_valid, 0);
                    pend_j = j;
                end
                if (!last) begin
                    if (gap_mode == 1 && k == 2)
                        for (int g = 0; g < 3; g++) pcyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                    if (gap_mode == 2 && $urandom_range(0, 3) == 0)
                        for (int g = 0; g < int'($urandom_range(1, 2)); g++) pcyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
                end
            end
        end
        bus.frame_n = 1'b1;
        bus.valid_n = 1'b1;
        pend_j = -1;
    endtask

    task automatic wait_not_busy();
        int t = 0;
        while (bus.busy_n == 1'b0 && t < 500) begin
            cyc(1'b1, 1'b1, 1'b0);
            t++;
        end
        if (t >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_timeout: got busy_n=0 expected 1 within 500 cycles");
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            cyc(1'b1, 1'b1, 1'b0);
            t++;
        end
        if (t >= 2000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: got %0d pending expected 0", tag, exp_q.size());
            exp_q.delete();
        end
        idle(3);
        chk({tag, "_empty"}, bus.out_valid, 0);
        chk({tag, "_proto_cnt"}, seen_proto, exp_proto);
        chk({tag, "_ovf_cnt"}, seen_ovf, exp_ovf);
    endtask

    initial begin
        int n, ab_b, ab_k;
        bit ab_v;
        logic [3:0] a;

        bus.frame_n = 1'b1;
        bus.valid_n = 1'b1;
        bus.din     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // basic packet with latency check
        rdy_mode = 1;
        chk_lat = 1;
        pl = {8'h5A, 8'h3C};
        send_pkt(4'hA, pl, 0, -1, 0, 0, 99, -1, 0);
        chk_lat = 0;
        drain("basic");

        // same packet with valid_n gaps
        chk_lat = 1;
        send_pkt(4'hA, pl, 1, -1, 0, 0, 99, -1, 0);
        chk_lat = 0;
        drain("gaps");

        // frame_n rises after 3 payload bits, then a clean packet to port 3
        send_pkt(4'hA, pl, 0, 0, 3, 0, 99, -1, 0);
        idle(2);
        pl = {8'h81};
        send_pkt(4'h3, pl, 0, -1, 0, 0, 99, -1, 0);
        drain("err_mid");

        // frame_n rises with valid_n low mid byte 2: byte 1 stays, without eop
        pl = {8'hC6, 8'h19};
        send_pkt(4'h7, pl, 0, 1, 5, 1, 99, -1, 0);
        idle(2);
        // framing errors in ADDR and PAD
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        exp_proto++;
        idle(1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        exp_proto++;
        idle(1);
        drain("err_misc");

        // overflow: 20 bytes with consumer stalled
        rdy_mode = 0;
        idle(2);
        chk("ovf_busy_before", bus.busy_n, 1);
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(i * 7 + 3));
        chk_busy = 1;
        send_pkt(4'h5, pl, 0, -1, 0, 0, DEPTH, -1, 0);
        chk_busy = 0;
        idle(3);
        chk("ovf_busy_held", bus.busy_n, 0);
        chk("ovf_head_valid", bus.out_valid, 1);
        chk("ovf_pulses", seen_ovf, exp_ovf);
        rdy_mode = 1;
        drain("ovf");
        chk("ovf_busy_after", bus.busy_n, 1);

        // reset during bit 5 of byte 2 with one entry queued
        rdy_mode = 0;
        pl = {8'h11, 8'h22};
        send_pkt(4'h9, pl, 0, -1, 0, 0, 99, 1, 5);
        idle(1);
        rdy_mode = 1;
        pl = {8'hC3};
        send_pkt(4'h6, pl, 0, -1, 0, 0, 99, -1, 0);
        drain("rst");

        // back-to-back packets
        pl = {8'h44, 8'h99};
        send_pkt(4'h2, pl, 0, -1, 0, 0, 99, -1, 0);
        pl = {8'hFF};
        send_pkt(4'hF, pl, 0, -1, 0, 0, 99, -1, 0);
        drain("b2b");

        // randomized traffic with random consumer back-pressure
        rdy_mode = 2;
        for (int p = 0; p < 40; p++) begin
            wait_not_busy();
            idle(int'($urandom_range(0, 2)));
            wait_not_busy();
            n = int'($urandom_range(1, 2));
            a = 4'($urandom);
            pl.delete();
            for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
            ab_b = -1;
            ab_k = 0;
            ab_v = 0;
            if ($urandom_range(0, 5) == 0) begin
                ab_b = int'($urandom_range(0, n - 1));
                ab_v = 1'($urandom_range(0, 1));
                ab_k = ab_v ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 7));
            end
            send_pkt(a, pl, 2, ab_b, ab_k, ab_v, 99, -1, 0);
        end
        rdy_mode = 1;
        drain("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
